// File: rtl/ysyx_25060173_mdu_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
// The execute stage is the master; the MDU is the slave.
interface ysyx_25060173_mdu_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      mdu_op;
  logic [XLEN-1:0] mdu_src1;
  logic [XLEN-1:0] mdu_src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] mdu_result;

  modport master (
    output flush, in_valid, mdu_op, mdu_src1, mdu_src2, out_ready,
    input  in_ready, out_valid, mdu_result
  );

  modport slave (
    input  flush, in_valid, mdu_op, mdu_src1, mdu_src2, out_ready,
    output in_ready, out_valid, mdu_result
  );
endinterface

// File: rtl/ysyx_25060173_mdu.sv
// RV32M iterative multiply/divide unit: one shift-add or restoring-divide step per cycle
// on operand magnitudes, with sign correction applied in a single fix-up cycle.
module ysyx_25060173_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_25060173_mdu_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg1_q, neg1_d, neg2_q, neg2_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept, is_div, s1_signed, s2_signed, src1_neg, src2_neg;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag1, mag2, special_res;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Operand classification happens on the raw inputs so it is ready on the accepting edge.
  assign accept    = bus.in_valid && (state_q == IDLE) && !bus.flush;
  assign is_div    = bus.mdu_op[2];
  assign s1_signed = (bus.mdu_op == 3'b001) || (bus.mdu_op == 3'b010) ||
                     (bus.mdu_op == 3'b100) || (bus.mdu_op == 3'b110);
  assign s2_signed = (bus.mdu_op == 3'b001) || (bus.mdu_op == 3'b100) ||
                     (bus.mdu_op == 3'b110);
  assign src1_neg  = s1_signed && bus.mdu_src1[XLEN-1];
  assign src2_neg  = s2_signed && bus.mdu_src2[XLEN-1];
  assign mag1      = src1_neg ? -bus.mdu_src1 : bus.mdu_src1;
  assign mag2      = src2_neg ? -bus.mdu_src2 : bus.mdu_src2;
  assign div_zero  = is_div && (bus.mdu_src2 == '0);
  assign div_ovf   = is_div && !bus.mdu_op[0] && (bus.mdu_src1 == MINV) && (bus.mdu_src2 == ONES);
  assign special   = div_zero || div_ovf;
  assign special_res = div_zero ? (bus.mdu_op[1] ? bus.mdu_src1 : ONES)
                                : (bus.mdu_op[1] ? '0 : bus.mdu_src1);

  // The remainder is always below the divisor, so only the shifted trial value needs XLEN+1 bits.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opa_q};

  assign prod_fix  = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
  assign quo_fix   = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix   = neg1_q ? -rem_q : rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) state_d = special ? DONE : CALC;
        CALC: if (cnt_q == '0) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready   = (state_q == IDLE);
    bus.out_valid  = (state_q == DONE);
    bus.mdu_result = result_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (!bus.flush) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_d   = bus.mdu_op;
            neg1_d = src1_neg;
            neg2_d = src2_neg;
            opa_d  = mag2;
            acc_d  = {{XLEN{1'b0}}, mag1};
            rem_d  = '0;
            cnt_d  = CNT_W'(XLEN - 1);
            if (special) result_d = special_res;
          end
        end
        CALC: begin
          if (op_q[2]) begin
            acc_d[XLEN-1:0] = {acc_q[XLEN-2:0], div_ge};
            rem_d = div_ge ? XLEN'(div_shift - {1'b0, opa_q}) : div_shift[XLEN-1:0];
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
        FIX: begin
          if (op_q[2])             result_d = op_q[1] ? rem_fix : quo_fix;
          else if (op_q == 3'b000) result_d = prod_fix[XLEN-1:0];
          else                     result_d = prod_fix[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      opa_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25060173_mdu.sv
// Self-checking bench for the multiply/divide unit: a transaction-level model predicts
// handshake timing and results every cycle, plus directed literal vectors.
module tb_ysyx_25060173_mdu;
  localparam int XLEN = 32;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   compared = 0;
  int   mismatched = 0;

  logic [31:0] expQ[$];
  int          latQ[$];
  int          edgesSince = 0;

  ysyx_25060173_mdu_if #(.XLEN(XLEN)) bus();

  ysyx_25060173_mdu #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic isSpecial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Plain two's-complement arithmetic on 64-bit values; RISC-V rules for the divide corner cases.
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                 else return 32'(ia / ib);
      OP_REM:    if (b == 0) return a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                 else return 32'(ia % ib);
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Transaction model: one outstanding op, fixed latency counted with the accepting edge as edge 1.
  always @(negedge clk) begin : monitor
    logic modelValid;
    logic acc;
    logic ret;
    if (rst) begin
      expQ.delete();
      latQ.delete();
      edgesSince = 0;
    end else begin
      modelValid = (expQ.size() != 0) && (edgesSince >= latQ[0]);
      checkOutput("in_ready", 32'(bus.in_ready), 32'(expQ.size() == 0));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(modelValid));
      if (modelValid) checkOutput("result", bus.mdu_result, expQ[0]);
      acc = bus.in_valid && (expQ.size() == 0) && !bus.flush;
      ret = modelValid && bus.out_ready && !bus.flush;
      if (bus.flush) begin
        expQ.delete();
        latQ.delete();
      end else if (acc) begin
        expQ.push_back(refModel(bus.mdu_op, bus.mdu_src1, bus.mdu_src2));
        latQ.push_back(isSpecial(bus.mdu_op, bus.mdu_src1, bus.mdu_src2) ? 1 : XLEN + 2);
        edgesSince = 1;
      end else if (ret) begin
        void'(expQ.pop_front());
        void'(latQ.pop_front());
      end else if (expQ.size() != 0) begin
        edgesSince++;
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int hold, input bit poke, output int edges, output logic [31:0] res);
    int guard;
    bus.mdu_op   = op;
    bus.mdu_src1 = a;
    bus.mdu_src2 = b;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.mdu_src1 = $urandom;
    bus.mdu_src2 = $urandom;
    bus.mdu_op   = 3'($urandom);
    edges = 1;
    while (!bus.out_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    if (!bus.out_valid) checkOutput("result timeout", 32'd0, 32'd1);
    res = bus.mdu_result;
    if (poke) bus.in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (poke) begin
        checkOutput("bp out_valid held", 32'(bus.out_valid), 32'd1);
        checkOutput("bp result stable", bus.mdu_result, res);
        checkOutput("bp in_ready low", 32'(bus.in_ready), 32'd0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    vec_t vecs[12];
    int edges;
    logic [31:0] res;
    logic sawValid;

    vecs[0]  = '{OP_MUL,    32'd7,           32'd6,           32'h0000_002A, 34};
    vecs[1]  = '{OP_MULH,   32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'h0000_0000, 34};
    vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFE, 34};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFF, 34};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD, 34};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF, 34};
    vecs[6]  = '{OP_DIVU,   32'hFFFF_FFF9,   32'd2,           32'h7FFF_FFFC, 34};
    vecs[7]  = '{OP_REMU,   32'hFFFF_FFF9,   32'd2,           32'h0000_0001, 34};
    vecs[8]  = '{OP_DIV,    32'd5,           32'd0,           32'hFFFF_FFFF, 1};
    vecs[9]  = '{OP_REMU,   32'd5,           32'd0,           32'h0000_0005, 1};
    vecs[10] = '{OP_DIV,    32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000, 1};
    vecs[11] = '{OP_REM,    32'h8000_0000,   32'hFFFF_FFFF,   32'h0000_0000, 1};

    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.mdu_op = '0;
    bus.mdu_src1 = '0;
    bus.mdu_src2 = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset result", bus.mdu_result, 32'd0);
    rst = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, edges, res);
      checkOutput($sformatf("vec%0d result", i), res, vecs[i].exp);
      checkOutput($sformatf("vec%0d latency", i), 32'(edges), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d in_ready after retire", i), 32'(bus.in_ready), 32'd1);
    end

    $display("[TB] backpressure");
    applyStimulus(OP_DIVU, 32'd1000, 32'd7, 10, 1'b1, edges, res);
    checkOutput("bp result", res, 32'd142);
    checkOutput("bp retired once", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("bp no re-accept", 32'(bus.in_ready), 32'd1);

    $display("[TB] flush mid-operation");
    bus.mdu_op = OP_MUL;
    bus.mdu_src1 = 32'h1234_5678;
    bus.mdu_src2 = 32'h9ABC_DEF0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("flush out_valid", 32'(bus.out_valid), 32'd0);
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) sawValid = 1'b1;
    end
    checkOutput("flush result discarded", 32'(sawValid), 32'd0);
    applyStimulus(OP_MULHU, 32'h8000_0000, 32'd4, 0, 1'b0, edges, res);
    checkOutput("post-flush MULHU", res, 32'h0000_0002);

    $display("[TB] async reset mid-operation");
    bus.mdu_op = OP_MULH;
    bus.mdu_src1 = 32'hDEAD_BEEF;
    bus.mdu_src2 = 32'h0000_0003;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("async rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async rst result", bus.mdu_result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(3'($urandom), pickOperand(), pickOperand(), $urandom_range(0, 3), 1'b0, edges, res);
    end
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
